i2s_tx: RTL
===========

# i2s_tx

Stereo I2S transmitter that consumes parallel 16-bit left/right sample pairs, such as the output of the sample player, and serializes them onto a standard Philips I2S link for an external DAC. A one-entry holding register with a valid/ready handshake decouples the sample source from the serial frame timing. The block generates BCLK, LRCLK and SDATA from the system clock.

## Interface
- `CLK_DIV`, default 4: i_clk cycles per BCLK half-period; legal range ≥ 2.
- `i_clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_left`  in  16  left sample, two's complement.
- `i_right`  in  16  right sample, two's complement.
- `i_valid`  in  1  sample pair valid.
- `o_ready`  out  1  holding register empty; transfer occurs when `i_valid & o_ready`.
- `o_bclk`  out  1  I2S bit clock.
- `o_lrclk`  out  1  I2S word select; 0 = left, 1 = right.
- `o_sdata`  out  1  I2S serial data, MSB first.
- `o_underrun`  out  1  one-cycle pulse when a frame starts with the holding register empty.

## Operation
- Reset values: `o_bclk`=0, `o_lrclk`=0, `o_sdata`=0, `o_ready`=1, `o_underrun`=0. The holding register is empty, the shift register is 0, and the slot counter is 31.
- Divider: `div_cnt` counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps and `o_bclk` toggles. A toggle from 1 to 0 is a *fall event*.
- Each fall event advances the slot counter `s` (5 bits, wraps 31→0). All serial outputs update only on fall events.
- Frame layout at slot `s`:
  - `o_lrclk` = 1 for s in 15..30, otherwise 0. Word select leads the data MSB by one BCLK.
  - `o_sdata` = left[15-s] for s in 0..15, and right[31-s] for s in 16..31.
- Frame start at the fall event entering s=0:
  - If the holding register is full, move the pair into a 32-bit shift register {left,right} and mark the holding register empty.
  - If the holding register is empty, load 0 and pulse `o_underrun` for one i_clk cycle.
- Handshake: `o_ready` is registered and equals !hold_full.
  - Accept in cycle t: `o_ready` is 0 from t+1.
  - Frame-start drain in cycle t: `o_ready` is 1 from t+1.
- Simultaneous accept and frame start in the same cycle: this is only possible when the holding register was empty. The frame takes the underrun path (zeros, pulse). The accepted pair is stored and transmitted in the next frame.
- `i_left`/`i_right` are sampled only on a transfer. While `o_ready`=0 they are ignored.
- Reset mid-frame returns all state to the reset values immediately. Any held or partially shifted sample is discarded.

## Timing
- BCLK period is 2·CLK_DIV i_clk cycles. A frame is 32 BCLK = 64·CLK_DIV cycles.
- After reset release:
  - The first rising edge of `o_bclk` occurs at cycle CLK_DIV.
  - The first fall event (slot 0) occurs at cycle 2·CLK_DIV.
- SDATA and LRCLK change on the same i_clk edge as BCLK falls, so the DAC samples them on the BCLK rise half a period later.
- Latency: a pair accepted at least one cycle before a frame start has its left MSB on `o_sdata` from that frame start. Worst case is about one frame plus one cycle.
- Sustained throughput is one pair per frame. The source may fill the holding register at any time during the frame.

## Structure
- Package `i2s_pkg`:
  - `SAMPLE_W`=16, `FRAME_SLOTS`=32.
  - Slot constants `LR_RISE_SLOT`=15 and `LR_FALL_SLOT`=31.
  - Typedef `stereo_t` as {left, right}.
- Sub-module `i2s_bclk_gen`: contains the divider and BCLK register, with outputs `o_bclk` and a one-cycle `o_fall` strobe. The top level holds the handshake, holding register, slot counter and shifter.

## Test plan
- Reset, then idle with `i_valid`=0 and CLK_DIV=4:
  - First BCLK rise at cycle 4.
  - `o_underrun` pulses at every frame start (every 256 cycles).
  - `o_sdata` stays 0.
  - `o_lrclk` is high for 16 BCLKs starting at slot 15.
- Push L=0x8001, R=0x7FFE once:
  - The next frame carries SDATA bits 1000…0001 then 0111…1110.
  - The LSB of left is transmitted while LRCLK=1.
  - The following frame underruns.
- Hold `i_valid`=1 with an incrementing counter pattern:
  - Exactly one transfer per frame.
  - No underrun after the first frame.
  - The decoded serial stream matches the pushed sequence in order with no gaps.
- Assert `i_valid` in exactly the frame-start cycle with the holding register empty:
  - `o_underrun` pulses.
  - The pair is transmitted in the following frame.
  - `o_ready` is 0 until that frame start.
- Assert `i_rst` at slot 20 mid-frame:
  - All outputs return to reset values within the cycle.
  - `o_ready`=1.
  - After release the first frame underruns and no stale bits appear.
- CLK_DIV=2: check frame period = 128 cycles and repeat the single-push check above.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S transmitter.
// Frame layout: 32 slots per frame, left word first, MSB first.
package i2s_pkg;

  localparam int SAMPLE_W    = 16;
  localparam int FRAME_SLOTS = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  localparam logic [SLOT_W-1:0] LR_RISE_SLOT = SLOT_W'(15);
  localparam logic [SLOT_W-1:0] LR_FALL_SLOT = SLOT_W'(31);

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_t;

  // Word select leads the data MSB by one BCLK
  function automatic logic lr_at(logic [SLOT_W-1:0] s);
    return (s >= LR_RISE_SLOT) && (s != LR_FALL_SLOT);
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// Bit clock generator: divides i_clk by 2*CLK_DIV.
// o_fall is high in the cycle whose closing edge drops o_bclk.
module i2s_bclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_bclk,
  output logic o_fall
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap   = (div_cnt == LAST);
  assign o_fall = wrap & o_bclk;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt <= '0;
      o_bclk  <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      o_bclk  <= ~o_bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// Stereo Philips I2S transmitter with a one-entry holding register.
// Serial outputs update on the same edge that drops BCLK.
import i2s_pkg::*;

module i2s_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_left,
  input  logic [15:0] i_right,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_bclk,
  output logic        o_lrclk,
  output logic        o_sdata,
  output logic        o_underrun
);

  logic              fall;
  logic              accept;
  logic              start;
  logic              hold_full;
  stereo_t           hold;
  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic [31:0]       shreg;

  i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_bclk (o_bclk),
    .o_fall (fall)
  );

  assign accept   = i_valid & o_ready;
  assign slot_nxt = slot + 1'b1;
  assign start    = fall && (slot == LR_FALL_SLOT);

  // Accept only when empty and drain only when full, so they never collide
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      hold      <= '0;
      hold_full <= 1'b0;
      o_ready   <= 1'b1;
    end else begin
      if (accept) begin
        hold      <= {i_left, i_right};
        hold_full <= 1'b1;
        o_ready   <= 1'b0;
      end else if (start && hold_full) begin
        hold_full <= 1'b0;
        o_ready   <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      slot       <= LR_FALL_SLOT;
      shreg      <= '0;
      o_sdata    <= 1'b0;
      o_lrclk    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_underrun <= start & ~hold_full;
      if (fall) begin
        slot    <= slot_nxt;
        o_lrclk <= lr_at(slot_nxt);
        if (start) begin
          shreg   <= hold_full ? 32'(hold) : 32'd0;
          o_sdata <= hold_full & hold[31];
        end else begin
          shreg   <= {shreg[30:0], 1'b0};
          o_sdata <= shreg[30];
        end
      end
    end
  end

endmodule
